im_fetch_unit: RTL and testbench



---
 rtl/im_fetch_unit.sv | 97 +++++++++
 tb/tb_im_fetch_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/im_fetch_unit.sv
// Instruction fetch unit: drives the IM word address and registers each
// fetched instruction into a valid/ready IF/ID output with redirect and halt.
module im_fetch_unit #(
    parameter int                 ADDR_W    = 5,
    parameter int                 DATA_W    = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [DATA_W-1:0]  HALT_INST = 32'hFFFFFFFF
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] addressIM,
    input  logic [DATA_W-1:0] inst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic              halted,
    output logic [7:0]        fetch_count
);

    typedef enum logic {
        FETCH,
        HALTED
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] opc_q, opc_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              accept;
    logic              handshake;

    assign handshake = valid_q && out_ready;
    assign accept    = (state_q == FETCH) && !redirect_valid
                       && (!valid_q || out_ready);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        inst_d  = inst_q;
        opc_d   = opc_q;
        cnt_d   = cnt_q;

        // Redirect squashes whatever is held and restarts fetch at the target
        if (redirect_valid) begin
            pc_d    = redirect_addr;
            valid_d = 1'b0;
            state_d = FETCH;
        end else if (accept) begin
            inst_d  = inst;
            opc_d   = pc_q;
            valid_d = 1'b1;
            if (inst == HALT_INST) begin
                state_d = HALTED;
            end else begin
                pc_d = pc_q + ADDR_W'(1);
            end
        end else if (handshake) begin
            valid_d = 1'b0;
        end

        if (handshake && cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            inst_q  <= '0;
            opc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            inst_q  <= inst_d;
            opc_q   <= opc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign addressIM   = pc_q;
    assign out_valid   = valid_q;
    assign out_inst    = inst_q;
    assign out_pc      = opc_q;
    assign halted      = (state_q == HALTED);
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_im_fetch_unit.sv
// Bench for im_fetch_unit: behavioural memory, scoreboard of expected
// deliveries popped on each handshake, plus direct per-cycle checks.
module tb_im_fetch_unit;

    logic        clk;
    logic        reset;
    logic [4:0]  addressIM;
    logic [31:0] inst;
    logic        redirect_valid;
    logic [4:0]  redirect_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [4:0]  out_pc;
    logic        halted;
    logic [7:0]  fetch_count;

    logic [31:0] mem [32];

    typedef struct packed {
        logic [4:0]  pc;
        logic [31:0] d;
    } exp_t;

    exp_t exp_q [$];

    int checks   = 0;
    int failures = 0;

    im_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .addressIM      (addressIM),
        .inst           (inst),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    assign inst = mem[addressIM];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] a);
        exp_t e;
        e.pc = a;
        e.d  = mem[a];
        exp_q.push_back(e);
    endtask

    // Handshake monitor: every delivery must match the next expected item
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", {27'd0, out_pc}, 32'hDEAD);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_pc", {27'd0, out_pc}, {27'd0, e.pc});
                check("sb_inst", out_inst, e.d);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + i;
        mem[0] = 32'd0;
        mem[1] = 32'd1;
        mem[2] = 32'd2;
        mem[4] = 32'hFFFF_FFFF;

        reset          = 1'b1;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        #2;
        check("rst_valid", {31'd0, out_valid}, 0);
        check("rst_addr", {27'd0, addressIM}, 0);
        check("rst_inst", out_inst, 0);
        check("rst_pc", {27'd0, out_pc}, 0);
        check("rst_halt", {31'd0, halted}, 0);
        check("rst_cnt", {24'd0, fetch_count}, 0);

        out_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
        check("addr0", {27'd0, addressIM}, 0);
        for (int i = 0; i < 5; i++) push(5'(i));

        // Sequential fetch into the halt word at address 4
        step();
        check("seq_addr1", {27'd0, addressIM}, 1);
        check("seq_pc0", {27'd0, out_pc}, 0);
        check("seq_valid", {31'd0, out_valid}, 1);
        step();
        check("seq_addr2", {27'd0, addressIM}, 2);
        check("seq_pc1", {27'd0, out_pc}, 1);
        step();
        check("seq_addr3", {27'd0, addressIM}, 3);
        check("seq_pc2", {27'd0, out_pc}, 2);
        step();
        check("seq_addr4", {27'd0, addressIM}, 4);
        check("seq_cnt3", {24'd0, fetch_count}, 3);
        step();
        check("halt_inst", out_inst, 32'hFFFF_FFFF);
        check("halt_flag", {31'd0, halted}, 1);
        check("halt_addr", {27'd0, addressIM}, 4);
        check("halt_valid", {31'd0, out_valid}, 1);
        step();
        check("halt_drain", {31'd0, out_valid}, 0);
        check("halt_cnt", {24'd0, fetch_count}, 5);
        step();
        check("halt_hold", {27'd0, addressIM}, 4);
        check("halt_idle", {31'd0, out_valid}, 0);

        // Redirect out of HALTED
        redirect_valid = 1'b1;
        redirect_addr  = 5'd0;
        step();
        redirect_valid = 1'b0;
        check("unhalt", {31'd0, halted}, 0);
        check("unhalt_addr", {27'd0, addressIM}, 0);
        check("unhalt_valid", {31'd0, out_valid}, 0);
        push(5'd0);
        push(5'd1);
        step();
        check("bp_pc0", {27'd0, out_pc}, 0);
        step();
        check("bp_pc1", {27'd0, out_pc}, 1);
        check("bp_cnt", {24'd0, fetch_count}, 6);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_hold_pc", {27'd0, out_pc}, 1);
            check("bp_hold_inst", out_inst, 1);
            check("bp_hold_addr", {27'd0, addressIM}, 2);
            check("bp_hold_cnt", {24'd0, fetch_count}, 6);
        end
        out_ready = 1'b1;
        step();
        check("bp_resume", {27'd0, out_pc}, 2);
        check("bp_resume_cnt", {24'd0, fetch_count}, 7);

        // Redirect while stalled squashes the held instruction
        out_ready = 1'b0;
        step();
        check("stall_pc", {27'd0, out_pc}, 2);
        redirect_valid = 1'b1;
        redirect_addr  = 5'd7;
        step();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        check("sq_valid", {31'd0, out_valid}, 0);
        check("sq_cnt", {24'd0, fetch_count}, 7);
        check("sq_addr", {27'd0, addressIM}, 7);
        push(5'd7);
        step();
        check("sq_pc7", {27'd0, out_pc}, 7);

        // Redirect with simultaneous handshake still counts the delivery
        mem[0]  = 32'hC;
        mem[30] = 32'hA;
        mem[31] = 32'hB;
        redirect_valid = 1'b1;
        redirect_addr  = 5'd30;
        step();
        redirect_valid = 1'b0;
        check("rdhs_valid", {31'd0, out_valid}, 0);
        check("rdhs_cnt", {24'd0, fetch_count}, 8);
        check("rdhs_addr", {27'd0, addressIM}, 30);
        push(5'd30);
        push(5'd31);
        push(5'd0);
        step();
        check("wrap_pc30", {27'd0, out_pc}, 30);
        step();
        check("wrap_pc31", {27'd0, out_pc}, 31);
        check("wrap_addr0", {27'd0, addressIM}, 0);
        step();
        check("wrap_pc0", {27'd0, out_pc}, 0);
        check("wrap_inst", out_inst, 32'hC);
        check("wrap_cnt", {24'd0, fetch_count}, 10);
        step();
        check("wrap_cnt2", {24'd0, fetch_count}, 11);
        out_ready = 1'b0;
        step();
        redirect_valid = 1'b1;
        redirect_addr  = 5'd8;
        step();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        step();
        check("pre_rst_pc", {27'd0, out_pc}, 8);
        check("pre_rst_addr", {27'd0, addressIM}, 9);
        out_ready = 1'b0;

        // Asynchronous reset between edges
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", {31'd0, out_valid}, 0);
        check("arst_addr", {27'd0, addressIM}, 0);
        check("arst_cnt", {24'd0, fetch_count}, 0);
        check("arst_pc", {27'd0, out_pc}, 0);
        step();
        step();
        out_ready = 1'b1;
        reset     = 1'b0;
        push(5'd0);
        step();
        check("post_rst_pc", {27'd0, out_pc}, 0);
        check("post_rst_inst", out_inst, 32'hC);

        // Long run to saturate fetch_count
        mem[4]         = 32'h44;
        redirect_valid = 1'b1;
        redirect_addr  = 5'd5;
        step();
        redirect_valid = 1'b0;
        check("sat_start", {24'd0, fetch_count}, 1);
        for (int i = 0; i < 260; i++) push(5'((5 + i) % 32));
        for (int k = 1; k <= 261; k++) begin
            step();
            if (k == 254) check("sat_254", {24'd0, fetch_count}, 254);
            if (k == 255) check("sat_255", {24'd0, fetch_count}, 255);
        end
        out_ready = 1'b0;
        check("sat_hold", {24'd0, fetch_count}, 255);
        step();
        check("sb_left", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
